// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding, default
//               oversampling ratio and data width. UART_TX_PARITY_EN widens
//               the state encoding to carry the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_W         = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
`endif

endpackage

`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
// ============================================================================
// Module      : uart_tx_bit_timer
// Description : Counts oversampling ticks and flags the tick that ends a bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic b_tick_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic [3:0] cnt_q, cnt_d;

  assign bit_end_o = enable_i && b_tick_i && (cnt_q == LAST_TICK);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && b_tick_i) begin
      cnt_d = bit_end_o ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : 8-bit UART transmitter, LSB first, driven by a shared
//               oversampling strobe. Define UART_TX_PARITY_EN to append an
//               even-parity bit after the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              b_tick,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timer_clr;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  uart_tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .b_tick_i  (b_tick),
    .enable_i  (state_q != IDLE),
    .clear_i   (timer_clr),
    .bit_end_o (bit_end)
  );

  // tx is registered from the next-state decision, so the line follows the
  // state change on the same edge without a combinational output path.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timer_clr  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start) begin
          state_d    = START;
          shift_d    = tx_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          timer_clr  = 1'b1;
          busy_d     = 1'b1;
          tx_d       = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = even_parity(tx_data);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, b_tick pulses per bit period (legal 8..16, 4-bit tick counter).
REQ-002 Parameter STOP_BITS, default 1, number of stop bits (legal 1 or 2).
REQ-003 Port clk  input  1  system clock, all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port b_tick  input  1  one-clk oversampling strobe from the shared baud generator.
REQ-006 Port tx_start  input  1  single-cycle or level request to send tx_data.
REQ-007 Port tx_data  input  8  byte to send, sampled only on acceptance.
REQ-008 Port tx  output  1  serial line, idle high, registered.
REQ-009 Port tx_busy  output  1  high from acceptance until the frame's last stop bit ends.
REQ-010 Port tx_done  output  1  one-clk pulse when a frame completes.

Function
REQ-011 States SHALL be IDLE, START, DATA, (PARITY when UART_TX_PARITY_EN), STOP.
REQ-012 IDLE: tx=1, tx_busy=0; tx_start=1 SHALL be accepted: latch tx_data, clear tick and bit counters, set tx_busy, go START.
REQ-013 tx SHALL go low the clk after acceptance (1-cycle latency), with tx_busy rising the same edge.
REQ-014 Tick counter SHALL increment only on b_tick; a bit period ends on the b_tick where counter==OVERSAMPLE-1, which also clears the counter.
REQ-015 START: tx=0 for one bit period, then DATA with bit counter 0.
REQ-016 DATA: tx=shift_reg[0] (LSB first); at each bit-period end shift right; after bit 7 go PARITY or STOP.
REQ-017 STOP: tx=1 for STOP_BITS bit periods; at the final period end go IDLE, clear tx_busy, pulse tx_done for exactly one clk.
REQ-018 tx_start while tx_busy=1 SHALL be ignored; latched byte and timing unaffected by tx_data changes mid-frame.
REQ-019 tx_start high in the clk where tx_done pulses (state IDLE) SHALL be accepted; next frame starts with no extra idle bit.
REQ-020 b_tick absent SHALL freeze the FSM in its current state and tx level indefinitely.
REQ-021 Frame length SHALL be exactly (10 + STOP_BITS - 1 [+1 parity]) x OVERSAMPLE b_ticks from first START tick to IDLE.

Reset
REQ-022 reset SHALL force state IDLE, tx=1, tx_busy=0, tx_done=0, counters and shift register 0, asynchronously, including mid-frame.
REQ-023 First edge after reset release SHALL be able to accept tx_start.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: PARITY state inserted after bit 7, tx = even parity (XOR of the 8 latched bits) for one bit period.
REQ-025 Macro UART_TX_PARITY_EN undefined: no PARITY state, no parity logic, DATA goes directly to STOP.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state encoding (2-bit, 3-bit with parity), default OVERSAMPLE=16 and data width 8, shared with the receiver.
REQ-027 A single sub-module uart_tx_bit_timer (tick counter, emits bit_end) is natural; FSM and shifter stay in uart_tx.

Verification
REQ-028 OVERSAMPLE=16, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 each 16 b_ticks, tx_done one clk at end, tx_busy high throughout.
REQ-029 Send 0xA3 with tx_data changed to 0xFF after acceptance -> bits 1,1,0,0,0,1,0,1 LSB first; second tx_start mid-frame ignored.
REQ-030 tx_start held high across tx_done, 0x01 then 0x80 -> second start bit immediately follows first stop bit, no gap.
REQ-031 reset asserted during DATA bit 4 -> tx=1, tx_busy=0 without clock edge; next tx_start 0x3C sends cleanly.
REQ-032 UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame 11 bit periods.
REQ-033 Loopback tx into uart_rx sharing b_tick, bytes 0x00, 0xFF, 0x5A -> rx_data matches each, rx_done once per byte.
